// File: rtl/alu_wb_pkg.sv
// Shared types for the ALU writeback stage: condition codes, the flags word,
// and the condition evaluation used by commit and bypass logic.
package alu_wb_pkg;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_CS = 3'd3,
    COND_CC = 3'd4,
    COND_MI = 3'd5,
    COND_PL = 3'd6,
    COND_VS = 3'd7
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic cond_pass(cond_e cond, flags_t f);
    cond_pass = 1'b1;
    case (cond)
      COND_EQ: cond_pass = f.z;
      COND_NE: cond_pass = !f.z;
      COND_CS: cond_pass = f.c;
      COND_CC: cond_pass = !f.c;
      COND_MI: cond_pass = f.n;
      COND_PL: cond_pass = !f.n;
      COND_VS: cond_pass = f.v;
      default: cond_pass = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_writeback_regfile_2r1w.sv
// Two-read, one-write register file with R0 hardwired to zero.
// Reads are combinational; the write lands at the rising edge.
module regfile_2r1w #(
  parameter int WIDTH = 3,
  parameter int REGS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(REGS)-1:0]  wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic [$clog2(REGS)-1:0]  ra1,
  input  logic [$clog2(REGS)-1:0]  ra2,
  output logic [WIDTH-1:0]         rd1,
  output logic [WIDTH-1:0]         rd2
);

  logic [WIDTH-1:0] mem_q [REGS];
  logic [WIDTH-1:0] mem_d [REGS];

  always_comb begin
    mem_d = mem_q;
    if (we && wa != '0) mem_d[wa] = wd;
  end

  // NOTE: the array is small enough to clear in reset; a large RAM would
  // not get a reset and would rely on software to initialise it instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: one pending entry, conditional commit to
// the register file and flags, and bypassed reads plus carry feedback.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int REGS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         result,
  input  logic                     n,
  input  logic                     z,
  input  logic                     c,
  input  logic                     v,
  input  logic [$clog2(REGS)-1:0]  rd,
  input  logic                     we_reg,
  input  logic                     we_flags,
  input  logic [2:0]               cond,
  input  logic                     hold,
  input  logic [$clog2(REGS)-1:0]  ra1,
  input  logic [$clog2(REGS)-1:0]  ra2,
  output logic [WIDTH-1:0]         rd1,
  output logic [WIDTH-1:0]         rd2,
  output logic [3:0]               flags,
  output logic                     carry_out,
  output logic                     commit,
  output logic                     skipped
);

  localparam int AW = $clog2(REGS);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    flags_t           fl;
    logic [AW-1:0]    rd;
    logic             we_reg;
    logic             we_flags;
    cond_e            cond;
  } pend_t;

  pend_t  pend_q, pend_d;
  flags_t flags_q, flags_d;

  logic             retiring;
  logic             pass;
  logic             rf_we;
  logic [WIDTH-1:0] rf_rd1, rf_rd2;

  assign in_ready = !hold;
  assign retiring = pend_q.valid && !hold;
  assign pass     = cond_pass(pend_q.cond, flags_q);
  assign rf_we    = retiring && pass && pend_q.we_reg;

  // NOTE: every always_comb output gets a default on its first line, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pend_d = pend_q;
    if (!hold) begin
      pend_d.valid = 1'b0;
      if (in_valid) begin
        pend_d.valid    = 1'b1;
        pend_d.result   = result;
        pend_d.fl       = '{n: n, z: z, c: c, v: v};
        pend_d.rd       = rd;
        pend_d.we_reg   = we_reg;
        pend_d.we_flags = we_flags;
        pend_d.cond     = cond_e'(cond);
      end
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (retiring && pass && pend_q.we_flags) flags_d = pend_q.fl;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      flags_q <= '0;
    end else begin
      pend_q  <= pend_d;
      flags_q <= flags_d;
    end
  end

  regfile_2r1w #(.WIDTH(WIDTH), .REGS(REGS)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .wa    (pend_q.rd),
    .wd    (pend_q.result),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  // The bypass ignores hold: a frozen entry that will commit is already
  // the newest value of its register.
  always_comb begin
    rd1 = rf_rd1;
    rd2 = rf_rd2;
    if (ra1 == '0) rd1 = '0;
    else if (pend_q.valid && pass && pend_q.we_reg && pend_q.rd == ra1) rd1 = pend_q.result;
    if (ra2 == '0) rd2 = '0;
    else if (pend_q.valid && pass && pend_q.we_reg && pend_q.rd == ra2) rd2 = pend_q.result;
  end

  assign carry_out = (pend_q.valid && pass && pend_q.we_flags) ? pend_q.fl.c : flags_q.c;
  assign flags     = flags_q;
  assign commit    = retiring && pass && (pend_q.we_reg || pend_q.we_flags);
  assign skipped   = retiring && !pass;

endmodule
